// File: rtl/us_scan_sequencer.sv
// us_scan_sequencer: shot sequencer for up to four ultrasonic transducer channels.
// Each period fires one enabled channel (round-robin), opens a receive gate, then holds off.
module us_scan_sequencer #(
  parameter int CH_N  = 4,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [7:0]       cfg_pw,
  input  logic [15:0]      cfg_gdly,
  input  logic [15:0]      cfg_glen,
  input  logic [15:0]      cfg_nshots,
  input  logic [CH_N-1:0]  cfg_mask,
  output logic             cfg_err,
  input  logic             start,
  input  logic             stop,
  output logic [CH_N-1:0]  fire,
  output logic             gate,
  output logic [1:0]       chan_id,
  output logic             shot_done,
  output logic             busy,
  output logic             run_done
);

  // Compare width wide enough for both the period counter and the 17-bit gate end.
  localparam int CMP_W = (CNT_W > 17) ? CNT_W : 17;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING} state_t;

  state_t r_state;
  state_t w_next_state;

  logic [CNT_W-1:0] r_period;
  logic [7:0]       r_pw;
  logic [15:0]      r_gdly;
  logic [15:0]      r_glen;
  logic [15:0]      r_nshots;
  logic [CH_N-1:0]  r_mask;

  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_shots;
  logic [1:0]       r_chan;

  logic [CH_N-1:0]  r_fire;
  logic             r_gate;
  logic [1:0]       r_chan_id;
  logic             r_run_done;
  logic             r_cfg_err;

  logic             w_active;
  logic             w_cfg_take;
  logic             w_cfg_bad;
  logic             w_start;
  logic             w_wrap;
  logic             w_last_shot;
  logic             w_leave;
  logic [16:0]      w_cfg_gend;
  logic [16:0]      w_gend;
  logic [CMP_W-1:0] w_cnt_x;
  logic [CH_N-1:0]  w_onehot;

  function automatic logic [1:0] f_lowest(input logic [CH_N-1:0] m);
    logic [1:0]      res;
    logic [CH_N-1:0] sh;
    res = 2'd0;
    for (int k = CH_N - 1; k >= 0; k--) begin
      sh = m >> k;
      if (sh[0]) res = 2'(k);
    end
    return res;
  endfunction

  // Search upward from the current channel, wrapping, for the next enabled one.
  function automatic logic [1:0] f_next(input logic [CH_N-1:0] m, input logic [1:0] cur);
    logic [1:0]      res;
    logic [CH_N-1:0] sh;
    logic            found;
    int              idx;
    res   = cur;
    found = 1'b0;
    for (int i = 1; i <= CH_N; i++) begin
      idx = (int'(cur) + i) % CH_N;
      sh  = m >> idx;
      if (!found && sh[0]) begin
        res   = 2'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign w_cfg_gend = {1'b0, cfg_gdly} + {1'b0, cfg_glen};
  assign w_cfg_bad  = (cfg_pw == 8'd0) || (cfg_glen == 16'd0) || (cfg_mask == '0) ||
                      (CMP_W'(cfg_period) < CMP_W'(cfg_pw)) ||
                      (CMP_W'(cfg_period) < CMP_W'(w_cfg_gend)) ||
                      (CMP_W'(cfg_period) < CMP_W'(2));

  assign w_active    = (r_state != S_IDLE);
  assign w_cfg_take  = (r_state == S_IDLE) && cfg_valid;
  assign w_start     = (r_state == S_IDLE) && start && !cfg_valid;
  assign w_wrap      = w_active && (r_cnt == r_period - CNT_W'(1));
  assign w_last_shot = (r_nshots != 16'd0) && (r_shots == r_nshots - 16'd1);
  assign w_gend      = {1'b0, r_gdly} + {1'b0, r_glen};
  assign w_cnt_x     = CMP_W'(r_cnt);
  assign w_onehot    = CH_N'(1) << r_chan;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (w_wrap && (w_last_shot || stop)) w_next_state = S_IDLE;
        else if (stop)                       w_next_state = S_STOPPING;
      end
      S_STOPPING: begin
        if (w_wrap) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
    shot_done = w_wrap;
    w_leave   = (r_state != S_IDLE) && (w_next_state == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= CNT_W'(125000);
      r_pw     <= 8'd50;
      r_gdly   <= 16'd100;
      r_glen   <= 16'd20000;
      r_nshots <= 16'd0;
      r_mask   <= CH_N'(1);
    end else if (w_cfg_take && !w_cfg_bad) begin
      r_period <= cfg_period;
      r_pw     <= cfg_pw;
      r_gdly   <= cfg_gdly;
      r_glen   <= cfg_glen;
      r_nshots <= cfg_nshots;
      r_mask   <= cfg_mask;
    end
  end

  // Period counter, shot counter and round-robin channel pointer advance together at the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shots <= 16'd0;
      r_chan  <= 2'd0;
    end else if (w_start) begin
      r_cnt   <= '0;
      r_shots <= 16'd0;
      r_chan  <= f_lowest(r_mask);
    end else if (w_wrap) begin
      r_cnt   <= '0;
      r_shots <= r_shots + 16'd1;
      r_chan  <= f_next(r_mask, r_chan);
    end else if (w_active) begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  // One register stage of decode from the counter; chan_id holds its last shot while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fire     <= '0;
      r_gate     <= 1'b0;
      r_chan_id  <= 2'd0;
      r_run_done <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_fire     <= (w_active && (w_cnt_x < CMP_W'(r_pw))) ? w_onehot : '0;
      r_gate     <= w_active && (w_cnt_x >= CMP_W'(r_gdly)) && (w_cnt_x < CMP_W'(w_gend));
      r_chan_id  <= w_active ? r_chan : r_chan_id;
      r_run_done <= w_leave;
      r_cfg_err  <= w_cfg_take && w_cfg_bad;
    end
  end

  assign fire     = r_fire;
  assign gate     = r_gate;
  assign chan_id  = r_chan_id;
  assign run_done = r_run_done;
  assign cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_us_scan_sequencer.sv
// Bench for us_scan_sequencer: directed and randomized runs checked every cycle
// against an arithmetic model indexed by cycle number since the start.
`timescale 1ns/1ps
module tb_us_scan_sequencer;
  localparam int CH_N  = 4;
  localparam int CNT_W = 24;
  localparam int NEVER = 32'h3fff_ffff;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period;
  logic [7:0]       cfg_pw;
  logic [15:0]      cfg_gdly;
  logic [15:0]      cfg_glen;
  logic [15:0]      cfg_nshots;
  logic [CH_N-1:0]  cfg_mask;
  logic             cfg_err;
  logic             start;
  logic             stop;
  logic [CH_N-1:0]  fire;
  logic             gate;
  logic [1:0]       chan_id;
  logic             shot_done;
  logic             busy;
  logic             run_done;

  us_scan_sequencer #(.CH_N(CH_N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_pw(cfg_pw), .cfg_gdly(cfg_gdly), .cfg_glen(cfg_glen),
    .cfg_nshots(cfg_nshots), .cfg_mask(cfg_mask), .cfg_err(cfg_err),
    .start(start), .stop(stop),
    .fire(fire), .gate(gate), .chan_id(chan_id),
    .shot_done(shot_done), .busy(busy), .run_done(run_done)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Model: shadow config plus the parameters and extent of the current (or last) run.
  int mPeriod, mPw, mGdly, mGlen, mNshots, mMask;
  bit running;
  int base, wEnd, heldChan, errAt;
  int rPeriod, rPw, rGdly, rGlen;
  int chanList[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h want %0h", tag, cycle, observed, expected);
    end
  endtask

  task automatic modelReset();
    mPeriod = 125000; mPw = 50; mGdly = 100; mGlen = 20000; mNshots = 0; mMask = 1;
    running = 1'b0; base = 0; wEnd = 0; heldChan = 0; errAt = -10;
    rPeriod = 2; rPw = 0; rGdly = 0; rGlen = 0;
    chanList.delete();
  endtask

  function automatic bit expBusy(input int c);
    return running && (c >= base) && (c <= wEnd);
  endfunction

  function automatic int shotChan(input int s);
    return chanList[s % chanList.size()];
  endfunction

  function automatic bit cfgIsValid();
    int p;
    p = int'(cfg_period);
    if (cfg_pw == 0 || cfg_glen == 0 || cfg_mask == 0) return 1'b0;
    if (p < int'(cfg_pw) || p < int'(cfg_gdly) + int'(cfg_glen) || p < 2) return 1'b0;
    return 1'b1;
  endfunction

  task automatic compareAll();
    logic [CH_N-1:0] eFire;
    logic eGate, eSd, eRd, eBusy, eErr;
    int eChan, k, s, ph, lastShot;
    eFire = '0; eGate = 1'b0; eSd = 1'b0; eRd = 1'b0;
    eBusy = expBusy(cycle);
    eErr  = (cycle == errAt + 1);
    eChan = heldChan;
    if (running) begin
      lastShot = (wEnd - base) / rPeriod;
      if (cycle >= base + 1) begin
        k = cycle - 1 - base;
        s = k / rPeriod;
        ph = k % rPeriod;
        eChan = shotChan((s > lastShot) ? lastShot : s);
        if (cycle <= wEnd + 1) begin
          if (ph < rPw) eFire = CH_N'(1) << shotChan(s);
          if (ph >= rGdly && ph < rGdly + rGlen) eGate = 1'b1;
        end
      end
      if (eBusy && ((cycle - base) % rPeriod) == rPeriod - 1) eSd = 1'b1;
      if (cycle == wEnd + 1) eRd = 1'b1;
    end
    checkOutput("fire", 32'(fire), 32'(eFire));
    checkOutput("gate", 32'(gate), 32'(eGate));
    checkOutput("chan_id", 32'(chan_id), 32'(eChan));
    checkOutput("shot_done", 32'(shot_done), 32'(eSd));
    checkOutput("busy", 32'(busy), 32'(eBusy));
    checkOutput("run_done", 32'(run_done), 32'(eRd));
    checkOutput("cfg_ready", 32'(cfg_ready), 32'(!eBusy));
    checkOutput("cfg_err", 32'(cfg_err), 32'(eErr));
  endtask

  // Drive inputs for the current cycle and let the model react to them.
  task automatic applyStimulus(input bit st, input bit sp, input bit cv);
    start = st; stop = sp; cfg_valid = cv;
    if (!expBusy(cycle)) begin
      if (cv) begin
        if (cfgIsValid()) begin
          mPeriod = int'(cfg_period); mPw = int'(cfg_pw); mGdly = int'(cfg_gdly);
          mGlen = int'(cfg_glen); mNshots = int'(cfg_nshots); mMask = int'(cfg_mask);
        end else begin
          errAt = cycle;
        end
      end else if (st) begin
        if (running) heldChan = shotChan((wEnd - base) / rPeriod);
        running = 1'b1;
        base = cycle + 1;
        rPeriod = mPeriod; rPw = mPw; rGdly = mGdly; rGlen = mGlen;
        wEnd = (mNshots != 0) ? base + mNshots * mPeriod - 1 : NEVER;
        chanList.delete();
        for (int i = 0; i < CH_N; i++) if (((mMask >> i) & 1) != 0) chanList.push_back(i);
      end
    end else if (sp) begin
      k_stop: begin
        int endOfShot;
        endOfShot = base + ((cycle - base) / rPeriod + 1) * rPeriod - 1;
        if (endOfShot < wEnd) wEnd = endOfShot;
      end
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    cycle++;
    #1;
    compareAll();
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      stepCycle();
    end
  endtask

  task automatic pulseReset();
    start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    modelReset();
    compareAll();
    @(posedge clk);
    cycle++;
    #1;
    compareAll();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic setCfg(input int p, input int pw, input int gd, input int gl, input int ns, input int m);
    cfg_period = CNT_W'(p); cfg_pw = 8'(pw); cfg_gdly = 16'(gd);
    cfg_glen = 16'(gl); cfg_nshots = 16'(ns); cfg_mask = CH_N'(m);
  endtask

  task automatic offerCfg();
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepCycle();
  endtask

  task automatic startRun();
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycle();
  endtask

  task automatic randomValidCfg();
    int p, pw, gl, gd;
    p  = $urandom_range(60, 2);
    pw = $urandom_range((p > 255) ? 255 : p, 1);
    gl = $urandom_range(p, 1);
    gd = $urandom_range(p - gl, 0);
    setCfg(p, pw, gd, gl, $urandom_range(5, 0), $urandom_range(15, 1));
  endtask

  task automatic randomInvalidCfg();
    randomValidCfg();
    case ($urandom_range(5, 0))
      0: cfg_pw = 8'd0;
      1: cfg_glen = 16'd0;
      2: cfg_mask = '0;
      3: cfg_pw = 8'(int'(cfg_period) + 1);
      4: cfg_gdly = 16'(cfg_period);
      default: begin cfg_period = CNT_W'(1); cfg_pw = 8'd1; cfg_gdly = 16'd0; cfg_glen = 16'd1; end
    endcase
  endtask

  task automatic runUntilIdle(input int budget, input int stopAt, input bit junkCfg);
    int guard;
    bit cv;
    guard = 0;
    while (cycle <= wEnd + 1 && guard < budget) begin
      cv = junkCfg && ($urandom_range(3, 0) == 0);
      if (cv) begin
        if ($urandom_range(1, 0) == 1) randomValidCfg();
        else randomInvalidCfg();
      end
      applyStimulus(1'b0, cycle == stopAt, cv);
      stepCycle();
      guard++;
    end
    checkOutput("runEndedInBudget", 32'(cycle > wEnd + 1), 32'd1);
    checkOutput("idleAfterRun", 32'(busy), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int stopAt;
    start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; rst_n = 1'b0;
    setCfg(0, 0, 0, 0, 0, 0);
    pulseReset();
    idleCycles(4);

    // Power-on shadow config: 50-cycle fire on ch0, gate from 100 for 20000 cycles.
    startRun();
    idleCycles(20300);
    pulseReset();
    idleCycles(3);

    setCfg(40, 3, 5, 10, 6, 4'b1011);
    offerCfg();
    idleCycles(2);
    startRun();
    runUntilIdle(400, -1, 1'b0);
    idleCycles(5);

    // Rejected configs must leave the previous shadow intact.
    setCfg(40, 0, 5, 10, 6, 4'b1011);
    offerCfg();
    idleCycles(2);
    setCfg(10, 3, 5, 6, 2, 4'b0001);
    offerCfg();
    idleCycles(2);
    startRun();
    runUntilIdle(400, -1, 1'b0);
    idleCycles(3);

    setCfg(40, 3, 5, 10, 0, 4'b1011);
    offerCfg();
    startRun();
    runUntilIdle(400, base + 47, 1'b0);
    idleCycles(60);

    setCfg(30, 4, 2, 8, 4, 4'b0110);
    offerCfg();
    startRun();
    runUntilIdle(400, -1, 1'b1);
    idleCycles(4);

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(1, 0) == 1) begin
        randomInvalidCfg();
        offerCfg();
      end
      randomValidCfg();
      offerCfg();
      idleCycles($urandom_range(3, 1));
      startRun();
      stopAt = (wEnd == NEVER) ? base + $urandom_range(3 * rPeriod, 0) : -1;
      runUntilIdle(1000, stopAt, 1'b1);
      idleCycles($urandom_range(3, 1));
    end

    setCfg(40, 3, 5, 10, 0, 4'b0001);
    offerCfg();
    startRun();
    idleCycles(1);
    pulseReset();
    idleCycles(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
